// File: rtl/uart_engine.sv
// 8-bit UART transmitter and receiver with independent FSMs, one stop bit.
// Define UART_ENGINE_PARITY_EN to add an even-parity bit after bit 7 on both paths.
module uart_engine #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       tx_ready,
    output logic       rx_ready,
    output logic       tx_busy,
    output logic       frame_err,
    output logic       parity_err
);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_baud, tx_baud_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_byte, tx_byte_n;
    logic        tx_n, tx_ready_n;

    always_comb begin
        tx_state_n = tx_state;
        tx_baud_n  = tx_baud + 16'd1;
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_n       = tx;
        tx_ready_n = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_baud_n = '0;
                tx_n      = 1'b1;
                if (tx_req) begin
                    tx_state_n = TX_START;
                    tx_byte_n  = tx_data;
                    tx_n       = 1'b0;
                end
            end
            TX_START: if (tx_baud == BIT_END) begin
                tx_baud_n  = '0;
                tx_bit_n   = '0;
                tx_state_n = TX_DATA;
                tx_n       = tx_byte[0];
            end
            TX_DATA: if (tx_baud == BIT_END) begin
                tx_baud_n = '0;
                tx_bit_n  = tx_bit + 3'd1;
                if (tx_bit == 3'd7) begin
`ifdef UART_ENGINE_PARITY_EN
                    tx_state_n = TX_PARITY;
                    tx_n       = ^tx_byte;
`else
                    tx_state_n = TX_STOP;
                    tx_n       = 1'b1;
`endif
                end else begin
                    tx_n = tx_byte[tx_bit + 3'd1];
                end
            end
`ifdef UART_ENGINE_PARITY_EN
            TX_PARITY: if (tx_baud == BIT_END) begin
                tx_baud_n  = '0;
                tx_state_n = TX_STOP;
                tx_n       = 1'b1;
            end
`endif
            TX_STOP: if (tx_baud == BIT_END) begin
                tx_baud_n  = '0;
                tx_state_n = TX_IDLE;
                tx_ready_n = 1'b1;
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_baud_n  = '0;
                tx_n       = 1'b1;
            end
        endcase
    end

    // tx_busy is registered from the next state so it is high exactly while the FSM is not idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_baud  <= tx_baud_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            tx       <= tx_n;
            tx_busy  <= (tx_state_n != TX_IDLE);
            tx_ready <= tx_ready_n;
        end
    end

    rx_state_t   rx_state, rx_state_n;
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic [15:0] rx_baud, rx_baud_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n, rx_data_n;
    logic        rx_ready_n, frame_err_n;
`ifdef UART_ENGINE_PARITY_EN
    logic        rx_par, rx_par_n, parity_err_q, parity_err_n;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_s = rx_sync[1];

    always_comb begin
        rx_state_n  = rx_state;
        rx_baud_n   = rx_baud + 16'd1;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_data_n   = rx_data;
        rx_ready_n  = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_ENGINE_PARITY_EN
        rx_par_n     = rx_par;
        parity_err_n = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_baud_n = '0;
                if (!rx_s) rx_state_n = RX_START;
            end
            // mid-start re-check rejects glitches shorter than half a bit
            RX_START: if (rx_baud == HALF_END) begin
                rx_baud_n  = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_baud == BIT_END) begin
                rx_baud_n  = '0;
                rx_shift_n = {rx_s, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) begin
`ifdef UART_ENGINE_PARITY_EN
                    rx_state_n = RX_PARITY;
`else
                    rx_state_n = RX_STOP;
`endif
                end
            end
`ifdef UART_ENGINE_PARITY_EN
            RX_PARITY: if (rx_baud == BIT_END) begin
                rx_baud_n  = '0;
                rx_par_n   = rx_s;
                rx_state_n = RX_STOP;
            end
`endif
            RX_STOP: if (rx_baud == BIT_END) begin
                rx_baud_n = '0;
                if (!rx_s) begin
                    frame_err_n = 1'b1;
                    rx_state_n  = RX_WAIT_IDLE;
                end else begin
                    rx_state_n = RX_IDLE;
`ifdef UART_ENGINE_PARITY_EN
                    if (rx_par != ^rx_shift) begin
                        parity_err_n = 1'b1;
                    end else begin
                        rx_data_n  = rx_shift;
                        rx_ready_n = 1'b1;
                    end
`else
                    rx_data_n  = rx_shift;
                    rx_ready_n = 1'b1;
`endif
                end
            end
            RX_WAIT_IDLE: begin
                rx_baud_n = '0;
                if (rx_s) rx_state_n = RX_IDLE;
            end
            default: begin
                rx_state_n = RX_IDLE;
                rx_baud_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync   <= 2'b11;
            rx_state  <= RX_IDLE;
            rx_baud   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_ENGINE_PARITY_EN
            rx_par       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_sync   <= {rx_sync[0], rx};
            rx_state  <= rx_state_n;
            rx_baud   <= rx_baud_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_data   <= rx_data_n;
            rx_ready  <= rx_ready_n;
            frame_err <= frame_err_n;
`ifdef UART_ENGINE_PARITY_EN
            rx_par       <= rx_par_n;
            parity_err_q <= parity_err_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_engine.sv
// Directed/randomized bench for uart_engine at CLKS_PER_BIT=8 against a frame-level model.
module tb_uart_engine;
    localparam int CPB = 8;
`ifdef UART_ENGINE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0, reset = 1'b1, tx_req = 1'b0, rx_drv = 1'b1, loop = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx, tx, tx_ready, rx_ready, tx_busy, frame_err, parity_err;
    logic [7:0] rx_data;

    assign rx = loop ? tx : rx_drv;

    uart_engine #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .tx_req(tx_req), .tx_data(tx_data), .rx(rx),
        .tx(tx), .rx_data(rx_data), .tx_ready(tx_ready), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rx_cnt = 0, fe_cnt = 0, pe_cnt = 0, txr_cnt = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_ready) begin
            rx_cnt <= rx_cnt + 1;
            rx_q.push_back(rx_data);
        end
        if (frame_err)  fe_cnt  <= fe_cnt + 1;
        if (parity_err) pe_cnt  <= pe_cnt + 1;
        if (tx_ready)   txr_cnt <= txr_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Line level of bit i of a frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (NBITS == 11 && i == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends d and checks tx/tx_busy/tx_ready on every cycle; ends in the tx_ready cycle
    task automatic tx_frame(input logic [7:0] d, input bit poke);
        tx_data = d;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
        tx_data = ~d;
        for (int k = 0; k <= NBITS * CPB; k++) begin
            check("tx_line", 16'(tx), 16'((k < NBITS * CPB) ? frame_bit(d, k / CPB) : 1'b1));
            check("tx_busy", 16'(tx_busy), 16'(k < NBITS * CPB));
            check("tx_ready", 16'(tx_ready), 16'(k == NBITS * CPB));
            tx_req = poke && (k == 20);
            if (poke && k == 20) tx_data = 8'h5A;
            if (k < NBITS * CPB) tick();
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input logic flip);
        logic b;
        for (int i = 0; i < NBITS; i++) begin
            b = frame_bit(d, i);
            if (i == NBITS - 1) b = stop;
            if (NBITS == 11 && i == 9) b = b ^ flip;
            rx_drv = b;
            repeat (CPB) tick();
        end
    endtask

    task automatic wait_tx_ready();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            if (tx_ready) seen = 1'b1;
            else tick();
        end
        check("tx_ready_timeout", 16'(seen), 16'd1);
    endtask

    task automatic expect_rx(input string tag, input int exp_cnt, input logic [7:0] d);
        logic [7:0] got;
        check({tag, "_cnt"}, 16'(rx_cnt), 16'(exp_cnt));
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check({tag, "_byte"}, 16'(got), 16'(d));
        check({tag, "_rx_data"}, 16'(rx_data), 16'(d));
    endtask

    initial begin
        int base_rx, base_fe, base_txr;
        logic [7:0] d, d2, last;

        repeat (3) tick();
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_busy", 16'(tx_busy), 16'd0);
        check("rst_tx_ready", 16'(tx_ready), 16'd0);
        check("rst_rx_ready", 16'(rx_ready), 16'd0);
        check("rst_frame_err", 16'(frame_err), 16'd0);
        check("rst_parity_err", 16'(parity_err), 16'd0);
        check("rst_rx_data", 16'(rx_data), 16'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Known pattern, then random bytes; one back-to-back pair and one ignored mid-frame request
        tx_frame(8'hA5, 1'b0);
        tick();
        tx_frame(8'h07, 1'b0);
        for (int n = 0; n < 3; n++) begin
            d = 8'($urandom);
            tx_frame(d, n == 1);
        end
        repeat (3) tick();

        // Randomized receive frames with 0..2 idle bits between them
        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            base_rx = rx_cnt;
            rx_frame(d, 1'b1, 1'b0);
            expect_rx("rx_rand", base_rx + 1, d);
            repeat ($urandom_range(0, 2) * CPB) tick();
        end

        // Loopback with back-to-back transmit
        loop = 1'b1;
        base_rx = rx_cnt;
        base_fe = fe_cnt;
        tx_data = 8'h3C;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
        wait_tx_ready();
        tx_data = 8'hC3;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
        wait_tx_ready();
        repeat (20) tick();
        check("loop_cnt", 16'(rx_cnt), 16'(base_rx + 2));
        check("loop_first", 16'((rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx), 16'h3C);
        check("loop_second", 16'((rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx), 16'hC3);
        check("loop_frame_err", 16'(fe_cnt), 16'(base_fe));
        loop = 1'b0;
        repeat (4) tick();

        // Simultaneous, unrelated TX and RX traffic
        d  = 8'($urandom);
        d2 = 8'($urandom);
        base_rx = rx_cnt;
        fork
            tx_frame(d, 1'b0);
            rx_frame(d2, 1'b1, 1'b0);
        join
        repeat (4) tick();
        expect_rx("concurrent", base_rx + 1, d2);

        // Short glitch on rx is rejected
        base_rx = rx_cnt;
        base_fe = fe_cnt;
        rx_drv = 1'b0;
        repeat (2) tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        check("glitch_rx_cnt", 16'(rx_cnt), 16'(base_rx));
        check("glitch_fe_cnt", 16'(fe_cnt), 16'(base_fe));
        d = 8'($urandom);
        rx_frame(d, 1'b1, 1'b0);
        expect_rx("after_glitch", base_rx + 1, d);

        // Stop bit 0 followed by a stuck-low line: one frame_err only
        last    = d;
        base_rx = rx_cnt;
        base_fe = fe_cnt;
        rx_frame(8'($urandom), 1'b0, 1'b0);
        repeat (40) tick();
        check("ferr_cnt", 16'(fe_cnt), 16'(base_fe + 1));
        check("ferr_rx_cnt", 16'(rx_cnt), 16'(base_rx));
        check("ferr_rx_data", 16'(rx_data), 16'(last));
        rx_drv = 1'b1;
        repeat (10) tick();
        check("ferr_cnt_idle", 16'(fe_cnt), 16'(base_fe + 1));
        d = 8'($urandom);
        rx_frame(d, 1'b1, 1'b0);
        expect_rx("after_ferr", base_rx + 1, d);

`ifdef UART_ENGINE_PARITY_EN
        last    = d;
        base_rx = rx_cnt;
        rx_frame(8'($urandom), 1'b1, 1'b1);
        repeat (4) tick();
        check("perr_cnt", 16'(pe_cnt), 16'd1);
        check("perr_rx_cnt", 16'(rx_cnt), 16'(base_rx));
        check("perr_rx_data", 16'(rx_data), 16'(last));
`else
        check("no_parity_err", 16'(pe_cnt), 16'd0);
`endif

        // Reset during data bit 3 aborts the frame at once
        base_txr = txr_cnt;
        tx_data = 8'hA5;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
        repeat (35) tick();
        check("pre_rst_busy", 16'(tx_busy), 16'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", 16'(tx), 16'd1);
        check("rst_mid_busy", 16'(tx_busy), 16'd0);
        tick();
        check("rst_mid_rx_data", 16'(rx_data), 16'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("rst_no_tx_ready", 16'(txr_cnt), 16'(base_txr));
        check("rst_tx_idle", 16'(tx), 16'd1);
        tx_frame(8'h01, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_engine.md
UART_ENGINE -- requirements
Module: uart_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (434 = 50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_req  input  1  start-transmit strobe; ignored unless TX idle.
REQ-005 SHALL have port tx_data  input  8  byte to transmit, sampled on the accepting tx_req edge.
REQ-006 SHALL have port rx  input  1  asynchronous serial input, idle high.
REQ-007 SHALL have port tx  output  1  serial output, idle high.
REQ-008 SHALL have port rx_data  output  8  last valid received byte.
REQ-009 SHALL have port tx_ready  output  1  one-cycle pulse when a frame completes.
REQ-010 SHALL have port rx_ready  output  1  one-cycle pulse when rx_data is updated.
REQ-011 SHALL have port tx_busy  output  1  high while TX FSM is not IDLE.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a received stop bit of 0.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse on RX parity mismatch; constant 0 without UART_ENGINE_PARITY_EN.

Function
REQ-014 Frame SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-031), one stop bit 1; every bit exactly CLKS_PER_BIT cycles.
REQ-015 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped without the macro.
REQ-016 In IDLE, tx_req=1 at an edge SHALL latch tx_data; tx goes low on that same edge (registered) and stays low CLKS_PER_BIT cycles.
REQ-017 tx_req while not IDLE SHALL be ignored, with no effect on the frame in flight or on the latched byte.
REQ-018 After the final stop-bit cycle, the FSM SHALL return to IDLE and assert tx_ready for exactly one cycle; a tx_req in that same cycle SHALL be accepted (back-to-back frames, no extra idle bit).
REQ-019 tx and tx_busy SHALL be registered outputs with no combinational path from any input.
REQ-020 rx SHALL pass through a 2-flop synchronizer; all RX decisions SHALL use the synchronized value only.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-022 IDLE->START on synchronized rx=0; at CLKS_PER_BIT/2 (integer division), rx=0 -> DATA, rx=1 -> IDLE (glitch rejected, no outputs).
REQ-023 DATA SHALL sample every CLKS_PER_BIT cycles from mid-start, 8 samples shifted LSB first.
REQ-024 At mid-stop, sample=1 and no parity error -> rx_data updated and rx_ready pulsed one cycle, then IDLE.
REQ-025 At mid-stop, sample=0 -> frame_err pulsed, rx_data unchanged, no rx_ready, then WAIT_IDLE; WAIT_IDLE->IDLE only once synchronized rx=1 (break/stuck-low produces one frame_err only).
REQ-026 Because rx_ready fires mid-stop, a following start edge SHALL be detected with zero idle bits between frames.
REQ-027 TX and RX SHALL be fully independent; simultaneous tx_req and rx activity SHALL not interact.
REQ-028 Bit counters SHALL be 3 bits, wrapping 7->0 only on the DATA exit; baud counters SHALL be 16 bits and reload to 0 at every bit boundary.

Reset
REQ-029 While reset=1: tx=1, tx_busy=0, tx_ready=0, rx_ready=0, frame_err=0, parity_err=0, rx_data=8'h00, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-030 Reset asserted mid-frame SHALL abort immediately (tx high asynchronously); the first tx_req after release SHALL start a clean frame.

Configuration
REQ-031 With UART_ENGINE_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) SHALL follow bit 7 on TX and be checked on RX; a mismatch SHALL pulse parity_err at mid-stop instead of rx_ready and leave rx_data unchanged; frame = 11 bits.
REQ-032 Without UART_ENGINE_PARITY_EN, no parity logic SHALL exist, parity_err SHALL be tied 0, and frame = 10 bits.

Verification (CLKS_PER_BIT=8)
REQ-033 tx_req with tx_data=8'hA5 -> tx low 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, high 8 cycles, tx_ready pulse at cycle 80, tx_busy high cycles 0-79.
REQ-034 Loopback rx=tx, send 8'h3C then 8'hC3 back-to-back -> two rx_ready pulses, rx_data 8'h3C then 8'hC3, frame_err never set.
REQ-035 rx low for 2 cycles then high -> no rx_ready/frame_err, RX back in IDLE and accepting the next valid frame.
REQ-036 Frame with stop bit 0 then rx held low 40 cycles -> one frame_err pulse, rx_data unchanged, no rx_ready until rx returns high and a new frame arrives.
REQ-037 Reset pulsed during data bit 3 of TX -> tx=1 immediately, no tx_ready; next tx_req 8'h01 transmits a correct full frame.
REQ-038 With UART_ENGINE_PARITY_EN: send 8'h07 -> parity bit 1, tx_ready at cycle 88; RX frame with flipped parity -> parity_err pulse, no rx_ready.
